// File: rtl/uart_sys_pkg.sv
// rtl/uart_sys_pkg.sv - opcodes and FSM state encoding shared by the UART command controller
package uart_sys_pkg;

  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_REQ  = 3'd5
  } state_t;

  // States in which the inter-byte timeout is running.
  function automatic logic timer_runs(state_t s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
           (s == ST_RD_ADDR) || (s == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/uart_ctrl_timer.sv
// rtl/uart_ctrl_timer.sv - clearable, enableable inter-byte timeout counter
// Ports:
//   clk, rst    : clock, async active-high reset
//   clr         : return count to zero (has priority over en)
//   en          : count up by one this cycle
//   expired     : count has reached timeoutCycles (count saturates there)
module uart_ctrl_timer #(
  parameter int timeoutCycles = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CntWidth = $clog2(timeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(timeoutCycles);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntMax);

endmodule

// File: rtl/uart_sys_ctrl.sv
// rtl/uart_sys_ctrl.sv - UART command framer driving the system register file
// Ports:
//   clk, rst                 : clock, async active-high reset
//   rx_p_data / rx_d_valid   : received byte and its one-cycle valid pulse
//   tx_busy                  : transmitter busy
//   tx_p_data / tx_d_valid   : read-back byte and transmit request
//   rf_addr, rf_wr_en, rf_wr_data, rf_rd_en : register file command side
//   rf_rd_data / rf_rd_valid : register file read return
//   cmd_error                : one-cycle pulse on bad opcode, timeout or dropped byte
module uart_sys_ctrl
  import uart_sys_pkg::*;
#(
  parameter int dataWidth     = 8,
  parameter int addrWidth     = 4,
  parameter int timeoutCycles = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] rx_p_data,
  input  logic                 rx_d_valid,
  input  logic                 tx_busy,
  output logic [dataWidth-1:0] tx_p_data,
  output logic                 tx_d_valid,
  output logic [addrWidth-1:0] rf_addr,
  output logic                 rf_wr_en,
  output logic [dataWidth-1:0] rf_wr_data,
  output logic                 rf_rd_en,
  input  logic [dataWidth-1:0] rf_rd_data,
  input  logic                 rf_rd_valid,
  output logic                 cmd_error
);

  state_t               state_q, state_d;
  logic [dataWidth-1:0] tx_p_data_q, tx_p_data_d;
  logic                 tx_d_valid_q, tx_d_valid_d;
  logic [addrWidth-1:0] rf_addr_q, rf_addr_d;
  logic                 rf_wr_en_q, rf_wr_en_d;
  logic [dataWidth-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                 rf_rd_en_q, rf_rd_en_d;
  logic                 cmd_error_q, cmd_error_d;
  logic                 busy_prev_q;
  logic                 timer_clr, timer_en, timer_expired;

  // A rising edge of tx_busy is the transmitter taking our byte; a level that
  // is already high belongs to a previous byte and keeps the request pending.
  logic tx_accept;
  assign tx_accept = tx_busy && !busy_prev_q;

  always_comb begin
    state_d      = state_q;
    tx_p_data_d  = tx_p_data_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    cmd_error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_d_valid) begin
          if (rx_p_data == dataWidth'(OP_WR))      state_d = ST_WR_ADDR;
          else if (rx_p_data == dataWidth'(OP_RD)) state_d = ST_RD_ADDR;
          else                                     cmd_error_d = 1'b1;
        end
      end
      ST_WR_ADDR: begin
        if (rx_d_valid) begin
          rf_addr_d = rx_p_data[addrWidth-1:0];
          state_d   = ST_WR_DATA;
        end else if (timer_expired) begin
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (rx_d_valid) begin
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_IDLE;
        end else if (timer_expired) begin
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_d_valid) begin
          rf_addr_d  = rx_p_data[addrWidth-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = ST_RD_WAIT;
        end else if (timer_expired) begin
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        cmd_error_d = rx_d_valid;
        // Returned data takes precedence over a simultaneous timeout.
        if (rf_rd_valid) begin
          tx_p_data_d = rf_rd_data;
          state_d     = ST_TX_REQ;
        end else if (timer_expired) begin
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_TX_REQ: begin
        cmd_error_d = rx_d_valid;
        if (tx_accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_d_valid_d = (state_d == ST_TX_REQ);
  end

  // Every accepted byte and every timeout changes state, so a state change is
  // exactly the set of events that restart the inter-byte window.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = timer_runs(state_q);

  uart_ctrl_timer #(
    .timeoutCycles(timeoutCycles)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_p_data_q  <= '0;
      tx_d_valid_q <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      cmd_error_q  <= 1'b0;
      busy_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_p_data_q  <= tx_p_data_d;
      tx_d_valid_q <= tx_d_valid_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      cmd_error_q  <= cmd_error_d;
      busy_prev_q  <= tx_busy;
    end
  end

  assign tx_p_data  = tx_p_data_q;
  assign tx_d_valid = tx_d_valid_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb/tb_uart_sys_ctrl.sv - self-checking bench for uart_sys_ctrl
module tb_uart_sys_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 40;

  localparam int EV_WR  = 1;
  localparam int EV_RD  = 2;
  localparam int EV_ERR = 3;
  localparam int EV_TX  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_p_data;
  logic          rx_d_valid;
  logic          tx_busy;
  logic [DW-1:0] tx_p_data;
  logic          tx_d_valid;
  logic [AW-1:0] rf_addr;
  logic          rf_wr_en;
  logic [DW-1:0] rf_wr_data;
  logic          rf_rd_en;
  logic [DW-1:0] rf_rd_data;
  logic          rf_rd_valid;
  logic          cmd_error;

  logic          rsp_valid, man_valid;
  logic [DW-1:0] rsp_data, man_data;
  assign rf_rd_valid = rsp_valid | man_valid;
  assign rf_rd_data  = man_valid ? man_data : rsp_data;

  int  errors = 0;
  int  checks = 0;
  int  rd_lat = 2;
  int  tx_len = 3;
  int  tx_left = 0;
  bit  rsp_enable = 1'b1;
  bit  busy_force = 1'b0;
  bit  prev_v = 1'b0;

  typedef struct {
    int kind;
    int a;
    int d;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];

  logic [7:0] rf_mem    [16];
  logic [7:0] model_mem [16];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int n;
    int gap;
    int wr;
    int rd;
    int err;
    int a;
    int d;
  } vec_t;

  vec_t vecs[10];

  uart_sys_ctrl #(
    .dataWidth(DW),
    .addrWidth(AW),
    .timeoutCycles(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_p_data  (rx_p_data),
    .rx_d_valid (rx_d_valid),
    .tx_busy    (tx_busy),
    .tx_p_data  (tx_p_data),
    .tx_d_valid (tx_d_valid),
    .rf_addr    (rf_addr),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_data (rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .cmd_error  (cmd_error)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input int k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_events(input string name);
    int n;
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count actual=%0d expected=%0d", name, act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i].kind != exp_q[i].kind || act_q[i].a != exp_q[i].a || act_q[i].d != exp_q[i].d) begin
        errors++;
        $display("FAIL %s event%0d actual=(k%0d a%0h d%0h) expected=(k%0d a%0h d%0h)", name, i,
                 act_q[i].kind, act_q[i].a, act_q[i].d, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Called right after a rising edge (+1); each byte occupies one full cycle.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_p_data  = b;
    rx_d_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_d_valid = 1'b0;
  endtask

  // Event monitor and register-file storage, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rf_wr_en) begin
        act_q.push_back(mk(EV_WR, int'(rf_addr), int'(rf_wr_data)));
        rf_mem[rf_addr] = rf_wr_data;
      end
      if (rf_rd_en)  act_q.push_back(mk(EV_RD, int'(rf_addr), 0));
      if (cmd_error) act_q.push_back(mk(EV_ERR, 0, 0));
      if (prev_v && !tx_d_valid) act_q.push_back(mk(EV_TX, 0, int'(tx_p_data)));
      prev_v = tx_d_valid;
    end
  end

  // Register file read responder: data rd_lat cycles after the strobe.
  initial begin
    logic [AW-1:0] a;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rf_rd_en && rsp_enable) begin
        a = rf_addr;
        repeat (rd_lat) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = rf_mem[a];
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
      end
    end
  end

  // Transmitter: raises busy when it sees a request while idle, stays busy tx_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_force) begin
        tx_busy = 1'b1;
        tx_left = 0;
      end else if (tx_left > 0) begin
        tx_left--;
        tx_busy = 1'b1;
      end else if (tx_d_valid && !tx_busy) begin
        tx_busy = 1'b1;
        tx_left = tx_len;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   kind, gap, t, a;
    logic [7:0] a8, d8, op;
    bit   stayed, seen;

    rst        = 1'b1;
    rx_p_data  = '0;
    rx_d_valid = 1'b0;
    man_valid  = 1'b0;
    man_data   = '0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'($urandom);
      rf_mem[i]    = model_mem[i];
    end
    model_mem[7] = 8'h3E;
    rf_mem[7]    = 8'h3E;

    //          b0     b1     b2     n  gap     wr rd err a     d
    vecs[0] = '{8'hAA, 8'h03, 8'h5C, 3, 1,      1, 0, 0,  3,    8'h5C};
    vecs[1] = '{8'h12, 8'h00, 8'h00, 1, 1,      0, 0, 1,  0,    0};
    vecs[2] = '{8'hAA, 8'h01, 8'hFF, 3, 1,      1, 0, 0,  1,    8'hFF};
    vecs[3] = '{8'hBB, 8'h07, 8'h00, 2, 1,      0, 1, 0,  7,    0};
    vecs[4] = '{8'hAA, 8'h04, 8'h00, 2, 1,      0, 0, 1,  0,    0};
    vecs[5] = '{8'h77, 8'h00, 8'h00, 1, 1,      0, 0, 1,  0,    0};
    vecs[6] = '{8'hAA, 8'hF9, 8'hC3, 3, 3,      1, 0, 0,  9,    8'hC3};
    vecs[7] = '{8'hAA, 8'h0A, 8'h11, 3, TO + 1, 1, 0, 0,  10,   8'h11};
    vecs[8] = '{8'hAA, 8'h0B, 8'h22, 3, TO + 2, 0, 0, 3,  0,    0};
    vecs[9] = '{8'hBB, 8'h05, 8'h00, 2, TO + 1, 0, 1, 0,  5,    0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_p_data", int'(tx_p_data), 0);
    chk("reset_tx_d_valid", int'(tx_d_valid), 0);
    chk("reset_rf_addr", int'(rf_addr), 0);
    chk("reset_rf_wr_en", int'(rf_wr_en), 0);
    chk("reset_rf_wr_data", int'(rf_wr_data), 0);
    chk("reset_rf_rd_en", int'(rf_rd_en), 0);
    chk("reset_cmd_error", int'(cmd_error), 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      put_byte(v.b0);
      if (v.n > 1) begin idle(v.gap - 1); put_byte(v.b1); end
      if (v.n > 2) begin idle(v.gap - 1); put_byte(v.b2); end
      idle(TO + 20);
      if (v.rd != 0) begin
        exp_q.push_back(mk(EV_RD, v.a, 0));
        exp_q.push_back(mk(EV_TX, 0, int'(model_mem[v.a])));
      end
      if (v.wr != 0) begin
        exp_q.push_back(mk(EV_WR, v.a, v.d));
        model_mem[v.a] = 8'(v.d);
      end
      for (int k = 0; k < v.err; k++) exp_q.push_back(mk(EV_ERR, 0, 0));
      check_events($sformatf("vec%0d", i));
    end

    // Transmitter busy with an earlier byte for 50 cycles; a stray byte arrives meanwhile.
    busy_force = 1'b1;
    idle(2);
    put_byte(8'hBB);
    put_byte(8'h06);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (tx_d_valid) seen = 1'b1;
      else idle(1);
    end
    chk("busy_tx_request_raised", int'(seen), 1);
    stayed = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (!tx_d_valid) stayed = 1'b0;
      if (k == 10) put_byte(8'h5A);
      else idle(1);
    end
    chk("busy_tx_valid_held", int'(stayed), 1);
    busy_force = 1'b0;
    idle(20);
    chk("busy_tx_valid_released", int'(tx_d_valid), 0);
    exp_q.push_back(mk(EV_RD, 6, 0));
    exp_q.push_back(mk(EV_ERR, 0, 0));
    exp_q.push_back(mk(EV_TX, 0, int'(model_mem[6])));
    check_events("busy_drop");

    // Read whose data never returns: timeout from the wait state.
    rsp_enable = 1'b0;
    put_byte(8'hBB);
    put_byte(8'h08);
    idle(TO + 20);
    chk("rdwait_timeout_no_tx", int'(tx_d_valid), 0);
    exp_q.push_back(mk(EV_RD, 8, 0));
    exp_q.push_back(mk(EV_ERR, 0, 0));
    check_events("rdwait_timeout");

    // Read data landing in the very cycle the wait times out.
    put_byte(8'hBB);
    put_byte(8'h09);
    idle(TO);
    man_data  = 8'hC7;
    man_valid = 1'b1;
    idle(1);
    man_valid = 1'b0;
    idle(20);
    exp_q.push_back(mk(EV_RD, 9, 0));
    exp_q.push_back(mk(EV_TX, 0, 8'hC7));
    check_events("rdvalid_at_timeout");

    // Read data outside a read is ignored.
    man_data  = 8'h99;
    man_valid = 1'b1;
    idle(1);
    man_valid = 1'b0;
    idle(10);
    chk("stray_rdvalid_no_tx", int'(tx_d_valid), 0);
    check_events("stray_rdvalid");
    rsp_enable = 1'b1;

    // Reset in the middle of a write frame.
    put_byte(8'hAA);
    put_byte(8'h02);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx_p_data", int'(tx_p_data), 0);
    chk("midrst_tx_d_valid", int'(tx_d_valid), 0);
    chk("midrst_rf_addr", int'(rf_addr), 0);
    chk("midrst_rf_wr_en", int'(rf_wr_en), 0);
    chk("midrst_rf_wr_data", int'(rf_wr_data), 0);
    chk("midrst_rf_rd_en", int'(rf_rd_en), 0);
    chk("midrst_cmd_error", int'(cmd_error), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    put_byte(8'hBB);
    put_byte(8'h02);
    idle(TO + 20);
    exp_q.push_back(mk(EV_RD, 2, 0));
    exp_q.push_back(mk(EV_TX, 0, int'(model_mem[2])));
    check_events("after_midframe_reset");

    // Randomized frames against a frame-level model.
    for (int f = 0; f < 60; f++) begin
      kind   = $urandom_range(0, 99);
      gap    = $urandom_range(1, TO - 2);
      rd_lat = $urandom_range(1, 4);
      tx_len = $urandom_range(1, 5);
      a8     = 8'($urandom);
      d8     = 8'($urandom);
      a      = int'(a8[3:0]);
      if (kind < 40) begin
        put_byte(8'hAA); idle(gap - 1); put_byte(a8); idle(gap - 1); put_byte(d8);
        exp_q.push_back(mk(EV_WR, a, int'(d8)));
        model_mem[a] = d8;
      end else if (kind < 70) begin
        put_byte(8'hBB); idle(gap - 1); put_byte(a8);
        exp_q.push_back(mk(EV_RD, a, 0));
        exp_q.push_back(mk(EV_TX, 0, int'(model_mem[a])));
      end else if (kind < 85) begin
        op = 8'($urandom);
        while (op == 8'hAA || op == 8'hBB) op = 8'($urandom);
        put_byte(op);
        exp_q.push_back(mk(EV_ERR, 0, 0));
      end else begin
        t = $urandom_range(0, 2);
        if (t == 0) put_byte(8'hAA);
        else if (t == 1) begin put_byte(8'hAA); idle(gap - 1); put_byte(a8); end
        else put_byte(8'hBB);
        exp_q.push_back(mk(EV_ERR, 0, 0));
      end
      idle(TO + 15);
    end
    check_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
